// File: rtl/sara_arbiter.sv
// -----------------------------------------------------------------------------
// sara_arbiter
//   Shares one SARA segmented adder between two requesters. A round-robin
//   arbiter grants one requester at a time. The winner's operands are latched
//   into operand registers, the combinational SARA evaluates them, and the
//   {cout, sum} pair is held in result registers. Only one transaction is in
//   flight at a time: IDLE (grant/accept) -> EXEC (compute) -> DONE (hold the
//   result until the consumer takes it).
//
//   SARA select semantics (NG = size/group_size groups, group 0 is the LSBs):
//     select[g] = 1 : group g takes the carry-in from below. For g = 0 that is
//                     the external carry-in; for g > 0 it is group g-1's carry-out.
//     select[g] = 0 : group g's carry-in is forced to 0.
//   The carry-out of the top group is always the adder carry-out. With every
//   select bit set, the SARA is an exact adder.
//
// Parameters
//   size        operand/sum width, must be a multiple of group_size
//   group_size  bits per SARA group
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b            requester N operands        [size-1:0]
//   reqN_cin                  requester N carry-in
//   reqN_select               requester N per-group select [NG-1:0]
//   res_valid / res_ready     result handshake
//   res_sum, res_cout         SARA result for the latched operands
//   res_id                    requester that owns the result
//
// Optional build macro SARA_ERR_MON_EN adds two outputs:
//   err_flag  1 when the latched result differs from the exact a+b+cin
//   err_cnt   16-bit saturating count of results with err_flag set
// -----------------------------------------------------------------------------

// Combinational segmented adder.
module sara_adder #(
  parameter int size       = 16,
  parameter int group_size = 4
) (
  input  logic [size-1:0]            a,
  input  logic [size-1:0]            b,
  input  logic                       cin,
  input  logic [size/group_size-1:0] select,
  output logic [size-1:0]            sum,
  output logic                       cout
);
  localparam int NG = size / group_size;

  logic [NG-1:0] grp_cin;
  logic [NG-1:0] grp_cout;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [group_size:0] grp_res;

    if (gi == 0) begin : g_first
      assign grp_cin[gi] = select[gi] & cin;
    end else begin : g_rest
      assign grp_cin[gi] = select[gi] & grp_cout[gi-1];
    end

    assign grp_res = {1'b0, a[gi*group_size +: group_size]}
                   + {1'b0, b[gi*group_size +: group_size]}
                   + {{group_size{1'b0}}, grp_cin[gi]};
    assign sum[gi*group_size +: group_size] = grp_res[group_size-1:0];
    assign grp_cout[gi] = grp_res[group_size];
  end

  assign cout = grp_cout[NG-1];
endmodule

module sara_arbiter #(
  parameter int size       = 16,
  parameter int group_size = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [size-1:0]            req0_a,
  input  logic [size-1:0]            req0_b,
  input  logic                       req0_cin,
  input  logic [size/group_size-1:0] req0_select,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [size-1:0]            req1_a,
  input  logic [size-1:0]            req1_b,
  input  logic                       req1_cin,
  input  logic [size/group_size-1:0] req1_select,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [size-1:0]            res_sum,
  output logic                       res_cout,
  output logic                       res_id
`ifdef SARA_ERR_MON_EN
  ,
  output logic                       err_flag,
  output logic [15:0]                err_cnt
`endif
);
  localparam int NG = size / group_size;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic [size-1:0] op_a_q;
  logic [size-1:0] op_b_q;
  logic            op_cin_q;
  logic [NG-1:0]   op_sel_q;
  logic            op_id_q;
  logic            res_valid_q;
  logic [size-1:0] res_sum_q;
  logic            res_cout_q;
  logic            res_id_q;

  // Arbitration: a lone requester wins; on a tie the requester that did not
  // win last time gets the grant.
  logic            grant1_d;
  logic            accept_d;
  logic [size-1:0] op_a_d;
  logic [size-1:0] op_b_d;
  logic            op_cin_d;
  logic [NG-1:0]   op_sel_d;

  always_comb begin
    grant1_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1_d = ~last_grant_q;
    end else begin
      grant1_d = req1_valid;
    end
  end

  // Ready is only offered in IDLE and never while reset is asserted.
  assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant1_d;
  assign req1_ready = ~rst & (state_q == IDLE) & grant1_d;
  assign accept_d   = req0_ready | req1_ready;

  assign op_a_d   = grant1_d ? req1_a      : req0_a;
  assign op_b_d   = grant1_d ? req1_b      : req0_b;
  assign op_cin_d = grant1_d ? req1_cin    : req0_cin;
  assign op_sel_d = grant1_d ? req1_select : req0_select;

  // The SARA only ever sees the operand registers.
  logic [size-1:0] sara_sum;
  logic            sara_cout;

  sara_adder #(
    .size       (size),
    .group_size (group_size)
  ) u_sara (
    .a      (op_a_q),
    .b      (op_b_q),
    .cin    (op_cin_q),
    .select (op_sel_q),
    .sum    (sara_sum),
    .cout   (sara_cout)
  );

`ifdef SARA_ERR_MON_EN
  logic [size:0] exact_sum;
  logic          err_flag_d;
  logic          err_flag_q;
  logic [15:0]   err_cnt_q;

  assign exact_sum  = {1'b0, op_a_q} + {1'b0, op_b_q} + {{size{1'b0}}, op_cin_q};
  assign err_flag_d = ({sara_cout, sara_sum} != exact_sum);
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_sel_q     <= '0;
      op_id_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
`ifdef SARA_ERR_MON_EN
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            op_sel_q     <= op_sel_d;
            op_id_q      <= grant1_d;
            last_grant_q <= grant1_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_sum_q   <= sara_sum;
          res_cout_q  <= sara_cout;
          res_id_q    <= op_id_q;
          res_valid_q <= 1'b1;
`ifdef SARA_ERR_MON_EN
          err_flag_q  <= err_flag_d;
          if (err_flag_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
`endif
          state_q     <= DONE;
        end
        DONE: begin
          // Hold the result until the consumer takes it; no timeout.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
endmodule

// File: tb/tb_sara_arbiter.sv
// Directed testbench for sara_arbiter (size=16, group_size=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sara_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic [3:0]  req0_select, req1_select;
  logic        res_valid, res_ready;
  logic [15:0] res_sum;
  logic        res_cout, res_id;
`ifdef SARA_ERR_MON_EN
  logic        err_flag;
  logic [15:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sara_arbiter #(.size(16), .group_size(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_cin    (req0_cin),
    .req0_select (req0_select),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_cin    (req1_cin),
    .req1_select (req1_select),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .res_id      (res_id)
`ifdef SARA_ERR_MON_EN
    ,
    .err_flag    (err_flag),
    .err_cnt     (err_cnt)
`endif
  );

  // Drives one request from a single requester and returns the result.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] sel,
                       output logic [15:0] sum, output logic cout, output logic rid,
                       output logic timeout);
    int n;
    timeout = 1'b0;
    @(negedge clk);
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_select = sel; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_select = sel; req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (((id == 1'b0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) timeout = 1'b1;
    sum  = res_sum;
    cout = res_cout;
    rid  = res_id;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0 || res_sum !== 16'h0000 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%b sum=%h rdy0=%b rdy1=%b, required 0 0000 0 0",
               res_valid, res_sum, req0_ready, req1_ready);
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_cnt !== 16'd0 || err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: cnt=%0d flag=%b, required 0 0", err_cnt, err_flag);
    end
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_single;
    @(negedge clk);
    req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0; req0_select = 4'h0;
    req0_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    vectors++;
    if (req0_ready !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exec: rdy0=%b valid=%b, required 0 0", req0_ready, res_valid);
    end
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b1 || res_sum !== 16'h0003 || res_cout !== 1'b0 || res_id !== 1'b0) begin
      miscompares++;
      $display("FAIL single_result: valid=%b sum=%h cout=%b id=%b, required 1 0003 0 0",
               res_valid, res_sum, res_cout, res_id);
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_flag !== 1'b0 || err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL single_err: flag=%b cnt=%0d, required 0 0", err_flag, err_cnt);
    end
`endif
    $display("single op: sum=%h cout=%b id=%b", res_sum, res_cout, res_id);
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_no_carry;
    logic [15:0] s; logic c, id, to;
    do_op(1'b1, 16'hF1E0, 16'hF000, 1'b1, 4'h1, s, c, id, to);
    vectors++;
    if (to || s !== 16'hE1E1 || c !== 1'b1 || id !== 1'b1) begin
      miscompares++;
      $display("FAIL no_carry: to=%b sum=%h cout=%b id=%b, required 0 e1e1 1 1", to, s, c, id);
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL no_carry_err: flag=%b, required 0", err_flag);
    end
`endif
    $display("no inter-group carry: sum=%h cout=%b id=%b", s, c, id);
  endtask

  // Carry chains cut or kept by the select word.
  task automatic test_segments;
    logic [15:0] s; logic c, id, to;
    // Fully chained: exact wrap-around.
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 4'hF, s, c, id, to);
    vectors++;
    if (to || s !== 16'h0000 || c !== 1'b1 || id !== 1'b0) begin
      miscompares++;
      $display("FAIL seg_exact: to=%b sum=%h cout=%b id=%b, required 0 0000 1 0", to, s, c, id);
    end
    $display("segments sel=F: sum=%h cout=%b", s, c);
    // All groups isolated: the group-0 carry is lost.
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 4'h0, s, c, id, to);
    vectors++;
    if (to || s !== 16'hFFF0 || c !== 1'b0) begin
      miscompares++;
      $display("FAIL seg_cut: to=%b sum=%h cout=%b, required 0 fff0 0", to, s, c);
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_flag !== 1'b1 || err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL seg_cut_err: flag=%b cnt=%0d, required 1 1", err_flag, err_cnt);
    end
`endif
    $display("segments sel=0: sum=%h cout=%b", s, c);
    // Only group 1 isolated; cin enters group 0.
    do_op(1'b1, 16'h000F, 16'h0000, 1'b1, 4'hD, s, c, id, to);
    vectors++;
    if (to || s !== 16'h0000 || c !== 1'b0 || id !== 1'b1) begin
      miscompares++;
      $display("FAIL seg_mid: to=%b sum=%h cout=%b id=%b, required 0 0000 0 1", to, s, c, id);
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_flag !== 1'b1 || err_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL seg_mid_err: flag=%b cnt=%0d, required 1 2", err_flag, err_cnt);
    end
`endif
    $display("segments sel=D: sum=%h cout=%b", s, c);
  endtask

  task automatic test_tie;
    logic [15:0] exp_sum [4];
    logic        exp_id  [4];
    int got, n;
    exp_sum = '{16'h0030, 16'h0300, 16'h0030, 16'h0300};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_a = 16'h0010; req0_b = 16'h0020; req0_cin = 1'b0; req0_select = 4'hF;
    req1_a = 16'h0100; req1_b = 16'h0200; req1_cin = 1'b0; req1_select = 4'hF;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    got = 0; n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) begin
        vectors++;
        if (res_id !== exp_id[got] || res_sum !== exp_sum[got]) begin
          miscompares++;
          $display("FAIL tie_%0d: id=%b sum=%h, required %b %h",
                   got, res_id, res_sum, exp_id[got], exp_sum[got]);
        end
        $display("tie result %0d: id=%b sum=%h", got, res_id, res_sum);
        got++;
      end
    end
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL tie_timeout: results=%0d, required 4", got);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_pressure;
    int n;
    logic [15:0] s0;
    res_ready = 1'b0;
    @(negedge clk);
    // last grant was 1, so req0 wins the tie here.
    req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b1; req0_select = 4'hF;
    req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 1'b0; req1_select = 4'hF;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_grant: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    s0 = res_sum;
    vectors++;
    if (s0 !== 16'h2346 || res_id !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_result: sum=%h id=%b, required 2346 0", s0, res_id);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b1 || res_sum !== 16'h2346 || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall_%0d: valid=%b sum=%h id=%b rdy0=%b rdy1=%b, required 1 2346 0 0 0",
                 i, res_valid, res_sum, res_id, req0_ready, req1_ready);
      end
    end
    $display("backpressure held 10 cycles: sum=%h", res_sum);
    res_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b rdy1=%b, required 0 1", res_valid, req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b1 || res_sum !== 16'h0007 || res_id !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next: valid=%b sum=%h id=%b, required 1 0007 1", res_valid, res_sum, res_id);
    end
    $display("backpressure next op: sum=%h id=%b", res_sum, res_id);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] s; logic c, id, to;
    @(negedge clk);
    req0_a = 16'h0005; req0_b = 16'h0003; req0_cin = 1'b0; req0_select = 4'hF;
    req0_valid = 1'b1;
    @(negedge clk);
    // Now in EXEC.
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: valid=%b, required 0", res_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_after_%0d: valid=%b, required 0", i, res_valid);
      end
    end
`ifdef SARA_ERR_MON_EN
    vectors++;
    if (err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_err: cnt=%0d, required 0", err_cnt);
    end
`endif
    $display("reset mid-op: no result emitted");
    do_op(1'b0, 16'h0007, 16'h0001, 1'b0, 4'hF, s, c, id, to);
    vectors++;
    if (to || s !== 16'h0008 || c !== 1'b0 || id !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_recover: to=%b sum=%h cout=%b id=%b, required 0 0008 0 0", to, s, c, id);
    end
    $display("after reset op: sum=%h id=%b", s, id);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_select = '0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_select = '0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_no_carry();
    test_segments();
    test_tie();
    test_back_pressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
